mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 125 ++++++++++++
 tb/tb_mac_accumulator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N_TERMS unsigned 8-bit products from the array
// multiplier into an ACC_W-bit dot product. Products come in on a
// valid/ready handshake. The finished sum goes out on its own valid/ready
// handshake, together with a sticky overflow flag.
//
// Optional feature: define MAC_ACC_SATURATE_EN to clamp the accumulator to
// all-ones on overflow. When it is undefined, the accumulator wraps modulo
// 2^ACC_W. In both builds ovf is set on overflow.
module mac_accumulator #(
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Count value seen just before the edge that accepts the final product
    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               xfer;
    logic [ACC_W:0]     sum;

    // A transfer can only happen in ACCUM, because prod_ready depends on state alone
    assign xfer = (state_q == ACCUM) && prod_valid;

    // The extra top bit of the sum catches the carry out of the accumulator
    assign sum = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE; DONE waits for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer && (cnt_q == LAST_CNT)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so prod never reaches acc_out combinationally
    always_comb begin
        prod_ready = (state_q == ACCUM);
        out_valid  = (state_q == DONE);
        busy       = (state_q == ACCUM) || (state_q == DONE);
        acc_out    = acc_q;
        ovf        = ovf_q;
    end

    // Datapath next values: clear on start; accumulate, count and flag overflow on each transfer
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == IDLE) begin
            if (start) begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | sum[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
        end
    end

    // Datapath registers: a reset discards any partial sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: drives three instances of mac_accumulator.
//   dut 0: default parameters (ACC_W=16, N_TERMS=8)
//   dut 1: ACC_W=8,  N_TERMS=2 (overflow behaviour)
//   dut 2: ACC_W=16, N_TERMS=1 (single-term dot product)
// Each stimulus sequence pushes its expected result into a queue. A negedge
// monitor pops that entry when a result handshake takes place.
module tb_mac_accumulator;

    logic clk;
    logic rst_n;

    logic [2:0]      start_v;
    logic [2:0]      prod_valid_v;
    logic [2:0]      out_ready_v;
    logic [2:0][7:0] prod_v;

    wire  [2:0]      prod_ready_v;
    wire  [2:0]      out_valid_v;
    wire  [2:0]      busy_v;
    wire  [2:0]      ovf_v;
    wire  [15:0]     acc0;
    wire  [7:0]      acc1;
    wire  [15:0]     acc2;

    int total;
    int bad;

    typedef struct {
        int          dut;
        logic [15:0] acc;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    mac_accumulator #(.ACC_W(16), .N_TERMS(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .prod(prod_v[0]),
        .prod_valid(prod_valid_v[0]), .prod_ready(prod_ready_v[0]),
        .acc_out(acc0), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .busy(busy_v[0]), .ovf(ovf_v[0])
    );

    mac_accumulator #(.ACC_W(8), .N_TERMS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .prod(prod_v[1]),
        .prod_valid(prod_valid_v[1]), .prod_ready(prod_ready_v[1]),
        .acc_out(acc1), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .busy(busy_v[1]), .ovf(ovf_v[1])
    );

    mac_accumulator #(.ACC_W(16), .N_TERMS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .prod(prod_v[2]),
        .prod_valid(prod_valid_v[2]), .prod_ready(prod_ready_v[2]),
        .acc_out(acc2), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .busy(busy_v[2]), .ovf(ovf_v[2])
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] get_acc(input int d);
        case (d)
            0:       return acc0;
            1:       return {8'h00, acc1};
            default: return acc2;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: on every result handshake, pop the oldest expected entry and compare
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst_n && out_valid_v[d] && out_ready_v[d]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: dut=%0d actual=0x%0h required=none", d, get_acc(d));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("result_dut", d, e.dut);
                    checkOutput("result_acc", get_acc(d), e.acc);
                    checkOutput("result_ovf", ovf_v[d], e.ovf);
                end
            end
        end
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
    endtask

    // Offer one product with valid high; it is accepted on the next edge while in ACCUM
    task automatic send(input int d, input logic [7:0] v);
        prod_v[d]       = v;
        prod_valid_v[d] = 1'b1;
        tick();
        prod_valid_v[d] = 1'b0;
    endtask

    // Wait (bounded) until the given instance returns to idle, then realign after a rising edge
    task automatic wait_idle(input int d);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy_v[d]) break;
        end
        if (k == 20) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout: dut=%0d actual=busy required=idle", d);
        end
        tick();
    endtask

    // Full dot product of n copies of v, with the expected result queued up front
    task automatic applyStimulus(input int d, input int n, input logic [7:0] v,
                                 input logic [15:0] exp_acc, input logic exp_ovf);
        exp_t e;
        e.dut = d;
        e.acc = exp_acc;
        e.ovf = exp_ovf;
        exp_q.push_back(e);
        pulse_start(d);
        checkOutput("accum_ready", prod_ready_v[d], 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) checkOutput("no_early_valid", out_valid_v[d], 1'b0);
            send(d, v);
        end
        @(negedge clk);
        checkOutput("latency_valid", out_valid_v[d], 1'b1);
        wait_idle(d);
    endtask

    // Bounded run time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] exp_sat;
        exp_t e;
        total        = 0;
        bad          = 0;
        start_v      = '0;
        prod_valid_v = '0;
        out_ready_v  = '1;
        prod_v       = '0;
        rst_n        = 1'b0;

        // Values while held in reset
        #2;
        checkOutput("reset_acc", acc0, 16'h0000);
        checkOutput("reset_valid", out_valid_v[0], 1'b0);
        checkOutput("reset_ready", prod_ready_v[0], 1'b0);
        checkOutput("reset_busy", busy_v[0], 1'b0);
        checkOutput("reset_ovf", ovf_v[0], 1'b0);
        #10 rst_n = 1'b1;
        tick();

        // 8 x 225 back to back
        applyStimulus(0, 8, 8'd225, 16'd1800, 1'b0);

        // Products 1..8 with valid toggling; garbage on idle cycles must be ignored
        e.dut = 0; e.acc = 16'd36; e.ovf = 1'b0;
        exp_q.push_back(e);
        pulse_start(0);
        for (int i = 1; i <= 8; i++) begin
            send(0, 8'(i));
            prod_v[0] = 8'hFF;
            if (i < 8) begin
                @(negedge clk);
                checkOutput("toggle_ready", prod_ready_v[0], 1'b1);
                tick();
            end
        end
        @(negedge clk);
        checkOutput("toggle_valid", out_valid_v[0], 1'b1);
        wait_idle(0);

        // Stall in DONE for 5 cycles with a start pulse in the middle
        out_ready_v[0] = 1'b0;
        e.dut = 0; e.acc = 16'd80; e.ovf = 1'b0;
        exp_q.push_back(e);
        pulse_start(0);
        for (int i = 0; i < 8; i++) send(0, 8'd10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_valid", out_valid_v[0], 1'b1);
            checkOutput("stall_acc", acc0, 16'd80);
            tick();
            start_v[0] = (k == 1);
        end
        start_v[0]     = 1'b0;
        out_ready_v[0] = 1'b1;
        tick();
        checkOutput("post_done_busy", busy_v[0], 1'b0);
        checkOutput("post_done_valid", out_valid_v[0], 1'b0);
        checkOutput("post_done_acc_hold", acc0, 16'd80);
        tick();
        checkOutput("start_ignored", busy_v[0], 1'b0);

        // Asynchronous reset after 3 of 8 transfers
        pulse_start(0);
        for (int i = 0; i < 3; i++) send(0, 8'd50);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_acc", acc0, 16'h0000);
        checkOutput("async_rst_busy", busy_v[0], 1'b0);
        checkOutput("async_rst_ready", prod_ready_v[0], 1'b0);
        checkOutput("async_rst_valid", out_valid_v[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 8, 8'd1, 16'd8, 1'b0);

        // ACC_W=8, N_TERMS=2: 225+225 = 450 overflows 8 bits
`ifdef MAC_ACC_SATURATE_EN
        exp_sat = 16'h00FF;
`else
        exp_sat = 16'h00C2;
`endif
        applyStimulus(1, 2, 8'd225, exp_sat, 1'b1);

        // N_TERMS=1: single product goes straight to DONE
        applyStimulus(2, 1, 8'h90, 16'h0090, 1'b0);

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
